// File: rtl/sim_memory_wbp.sv
// sim_memory_wbp: byte-addressed simulation memory behind a Wishbone-classic
// slave handshake. It supports a configurable address and data width, byte-lane
// selects and unaligned multi-byte access with AW-bit address wrap. A
// programmable number of wait states is inserted before the termination pulse.
//
// Optional feature macro: MEM_BOUNDS_EN
//   When defined, an access that selects any lane at an address >= MEM_BYTES
//   terminates with err_o instead of ack_o. Such an access writes nothing and
//   leaves dat_o unchanged. MEM_BYTES may then be any value >= DW/8.
//   When undefined, err_o stays 0 and lane addresses fold modulo MEM_BYTES.
//   In that case MEM_BYTES must be a power of two.
//
// Handshake: a request is cyc_i & stb_i sampled at a rising clock edge. The
// slave answers with exactly one single-cycle ack_o (or err_o) pulse per
// accepted request. If the master drops the request during wait states, the
// access is abandoned silently. The master must drop stb_i after the pulse,
// or the still-asserted request is taken as a new access.
module sim_memory_wbp #(
   parameter int          AW        = 20,
   parameter int          DW        = 16,
   parameter int unsigned MEM_BYTES = 2**AW,
   parameter int          WAIT      = 0,
   parameter string       INIT_FILE = "",
   parameter int unsigned INIT_BASE = 'hf0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            we_i,
   input  logic [AW-1:0]   adr_i,
   input  logic [DW/8-1:0] sel_i,
   input  logic [DW-1:0]   dat_i,
   output logic [DW-1:0]   dat_o,
   output logic            ack_o,
   output logic            err_o
);

   localparam int N  = DW / 8;
   localparam int IW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [7:0]    mem [0:MEM_BYTES-1];

   logic [1:0]    state;
   logic [3:0]    wcnt;
   logic          lat_we;
   logic [AW-1:0] lat_adr;
   logic [N-1:0]  lat_sel;
   logic [DW-1:0] lat_dat;

   logic          req;
   logic          cur_we;
   logic [AW-1:0] cur_adr;
   logic [N-1:0]  cur_sel;
   logic [DW-1:0] cur_dat;
   logic [AW-1:0] lane_adr [N];
   logic [IW-1:0] lane_idx [N];
   logic          oob;
   logic          enter_ack;
   logic [DW-1:0] rd_data;

   assign req = cyc_i & stb_i;

   // Select the access being completed. In IDLE it is the live bus request,
   // which matters for WAIT=0. Otherwise it is the request captured on acceptance.
   always_comb begin
      cur_we  = lat_we;
      cur_adr = lat_adr;
      cur_sel = lat_sel;
      cur_dat = lat_dat;
      if (state == S_IDLE) begin
         cur_we  = we_i;
         cur_adr = adr_i;
         cur_sel = sel_i;
         cur_dat = dat_i;
      end
   end

   // Per-lane byte addresses. Wrap is plain AW-bit addition, and the storage
   // index keeps the low IW bits.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         lane_adr[k] = cur_adr + AW'(k);
         lane_idx[k] = IW'(lane_adr[k]);
      end
   end

   // Out-of-range detection. Only selected lanes count.
`ifdef MEM_BOUNDS_EN
   always_comb begin
      oob = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (cur_sel[k] && (64'(lane_adr[k]) >= 64'(MEM_BYTES))) oob = 1'b1;
      end
   end
`else
   assign oob = 1'b0;
`endif

   // The edge that moves the FSM into ACK is the commit/capture edge.
   always_comb begin
      enter_ack = 1'b0;
      case (state)
         S_IDLE:  enter_ack = req && (WAIT == 0);
         S_WAIT:  enter_ack = req && (wcnt == 4'd1);
         default: enter_ack = 1'b0;
      endcase
   end

   // Read-data assembly. Unselected lanes return zero.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < N; k++) begin
         if (cur_sel[k]) rd_data[8*k +: 8] = mem[lane_idx[k]];
      end
   end

   // Control FSM, wait counter, request latch and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         wcnt    <= 4'd0;
         lat_we  <= 1'b0;
         lat_adr <= '0;
         lat_sel <= '0;
         lat_dat <= '0;
         dat_o   <= '0;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         if (enter_ack) begin
            ack_o <= !oob;
            err_o <= oob;
            if (!cur_we && !oob) dat_o <= rd_data;
         end
         case (state)
            S_IDLE: begin
               if (req) begin
                  lat_we  <= we_i;
                  lat_adr <= adr_i;
                  lat_sel <= sel_i;
                  lat_dat <= dat_i;
                  if (WAIT == 0) begin
                     state <= S_ACK;
                  end else begin
                     wcnt  <= 4'(WAIT);
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!req) begin
                  wcnt  <= 4'd0;
                  state <= S_IDLE;
               end else if (wcnt == 4'd1) begin
                  wcnt  <= 4'd0;
                  state <= S_ACK;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            S_ACK:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Byte-lane write commit. Gating with rst_n keeps a reset edge from writing.
   always_ff @(posedge clk) begin
      if (rst_n && enter_ack && cur_we && !oob) begin
         for (int k = 0; k < N; k++) begin
            if (cur_sel[k]) mem[lane_idx[k]] <= cur_dat[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sim_memory_wbp.sv
// Bench for sim_memory_wbp. Two instances are used: u_dut0 has no wait states
// and u_dut3 has three. A byte-level reference model predicts each
// termination, and a negedge monitor consumes those predictions.
module tb_sim_memory_wbp;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int N  = 2;
`ifdef MEM_BOUNDS_EN
  localparam int unsigned MB0 = 'h80000;
`else
  localparam int unsigned MB0 = 1 << 20;
`endif
  localparam int unsigned MB1 = 1 << 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc [2];
  logic          stb [2];
  logic          we [2];
  logic [AW-1:0] adr [2];
  logic [N-1:0]  sel [2];
  logic [DW-1:0] wdat [2];
  logic [DW-1:0] rdat [2];
  logic          ack [2];
  logic          err [2];

  int checks = 0;
  int errors = 0;

  // expected termination: {is_err, data[15:0], lane mask[15:0]}
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [7:0]  mdl[int];
  logic [15:0] last_d [2];
  logic [15:0] last_m [2];

  // clock / reset block
  always #5 clk = ~clk;

  sim_memory_wbp #(.AW(AW), .DW(DW), .MEM_BYTES(MB0), .WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .sel_i(sel[0]), .dat_i(wdat[0]), .dat_o(rdat[0]),
    .ack_o(ack[0]), .err_o(err[0]));

  sim_memory_wbp #(.AW(AW), .DW(DW), .MEM_BYTES(MB1), .WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .sel_i(sel[1]), .dat_i(wdat[1]), .dat_o(rdat[1]),
    .ack_o(ack[1]), .err_o(err[1]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int unsigned membytes(input int d);
    return (d == 0) ? MB0 : MB1;
  endfunction

  function automatic int key(input int d, input logic [AW-1:0] a);
    return d * (1 << AW) + int'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed storage, AW-bit wrap and optional bounds.
  // For reads, bytes never written have a zero mask and are not compared.
  task automatic predict(input int d, input logic w, input logic [AW-1:0] a,
                         input logic [N-1:0] s, input logic [DW-1:0] wd,
                         output logic [32:0] e);
    logic [AW-1:0] la;
    logic          is_err;
    logic [15:0]   nd, nm;
    is_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      la = a + AW'(k);
      if (s[k] && (int'(la) >= membytes(d))) is_err = 1'b1;
    end
    if (is_err) begin
      e = {1'b1, last_d[d], last_m[d]};
    end else if (w) begin
      for (int k = 0; k < N; k++) begin
        la = a + AW'(k);
        if (s[k]) mdl[key(d, la)] = wd[8*k +: 8];
      end
      e = {1'b0, last_d[d], last_m[d]};
    end else begin
      nd = '0;
      nm = '0;
      for (int k = 0; k < N; k++) begin
        la = a + AW'(k);
        if (!s[k]) begin
          nm[8*k +: 8] = 8'hff;
        end else if (mdl.exists(key(d, la))) begin
          nd[8*k +: 8] = mdl[key(d, la)];
          nm[8*k +: 8] = 8'hff;
        end
      end
      last_d[d] = nd;
      last_m[d] = nm;
      e = {1'b0, nd, nm};
    end
  endtask

  // Driver: one access. If drop_after > 0, the request is withdrawn after
  // that many edges, and no termination may follow.
  task automatic access(input int d, input logic w, input logic [AW-1:0] a,
                        input logic [N-1:0] s, input logic [DW-1:0] wd,
                        input int drop_after, output logic [DW-1:0] rd);
    logic [32:0] e;
    int          n;
    logic        done, bad;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
    rd = '0;
    if (drop_after < 0) begin
      predict(d, w, a, s, wd, e);
      if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
        @(posedge clk); n++; #1;
        if (ack[d] || err[d]) done = 1'b1;
      end
      rd = rdat[d];
      cyc[d] = 1'b0; stb[d] = 1'b0;
      check("ack_seen", {31'b0, done}, 32'd1);
      if (!done) begin
        if (d == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
      end else begin
        check("latency", n, wait_of(d) + 1);
        @(posedge clk); #1;
        check("pulse_width", {30'b0, ack[d], err[d]}, 32'd0);
      end
    end else begin
      repeat (drop_after) @(posedge clk);
      #1;
      cyc[d] = 1'b0; stb[d] = 1'b0;
      bad = 1'b0;
      repeat (wait_of(d) + 2) begin
        @(posedge clk); #1;
        if (ack[d] || err[d]) bad = 1'b1;
      end
      check("abort_no_ack", {31'b0, bad}, 32'd0);
    end
  endtask

  // Scoreboard monitor: each termination pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ack[d] || err[d]) begin
          logic [32:0] e;
          if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_term dut%0d: ack %b err %b, none expected", d, ack[d], err[d]);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("term_err", {31'b0, err[d]}, {31'b0, e[32]});
            check("term_ack", {31'b0, ack[d]}, {31'b0, !e[32]});
            check("dat_o", {16'b0, rdat[d] & e[15:0]}, {16'b0, e[31:16] & e[15:0]});
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]  rd;
    logic [AW-1:0]  a;
    int             d, drop;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; sel[i] = '0; wdat[i] = '0;
      last_d[i] = '0; last_m[i] = 16'hffff;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ack", {31'b0, ack[i]}, 32'd0);
      check("reset_err", {31'b0, err[i]}, 32'd0);
      check("reset_dat", {16'b0, rdat[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // aligned word
    access(0, 1'b1, 20'h00100, 2'b11, 16'h1234, -1, rd);
    access(0, 1'b0, 20'h00100, 2'b11, 16'h0000, -1, rd);
    check("word_read", {16'b0, rd}, 32'h1234);
    access(0, 1'b0, 20'h00100, 2'b01, 16'h0000, -1, rd);
    check("byte_100", {16'b0, rd}, 32'h0034);
    access(0, 1'b0, 20'h00101, 2'b01, 16'h0000, -1, rd);
    check("byte_101", {16'b0, rd}, 32'h0012);

    // byte lanes
    access(0, 1'b1, 20'h00200, 2'b11, 16'h5566, -1, rd);
    access(0, 1'b1, 20'h00200, 2'b10, 16'hABCD, -1, rd);
    access(0, 1'b0, 20'h00200, 2'b11, 16'h0000, -1, rd);
    check("lane_hi_only", {16'b0, rd}, 32'hAB66);
    access(0, 1'b0, 20'h00200, 2'b01, 16'h0000, -1, rd);
    check("lane_lo_read", {16'b0, rd}, 32'h0066);

    // sel = 0 completes with zero read data and no write
    access(0, 1'b0, 20'h00100, 2'b00, 16'h0000, -1, rd);
    check("sel0_read", {16'b0, rd}, 32'h0000);
    access(0, 1'b1, 20'h00100, 2'b00, 16'hFFFF, -1, rd);
    access(0, 1'b0, 20'h00100, 2'b11, 16'h0000, -1, rd);
    check("sel0_nowrite", {16'b0, rd}, 32'h1234);

`ifndef MEM_BOUNDS_EN
    // unaligned access wrapping past the top of the address space
    access(0, 1'b1, 20'hfffff, 2'b11, 16'hBEEF, -1, rd);
    access(0, 1'b0, 20'hfffff, 2'b11, 16'h0000, -1, rd);
    check("wrap_read", {16'b0, rd}, 32'hBEEF);
    access(0, 1'b0, 20'h00000, 2'b01, 16'h0000, -1, rd);
    check("wrap_byte0", {16'b0, rd}, 32'h00BE);
    access(0, 1'b0, 20'hfffff, 2'b01, 16'h0000, -1, rd);
    check("wrap_topbyte", {16'b0, rd}, 32'h00EF);
`else
    // bounds: the upper lane of 'h7ffff lies outside the storage
    access(0, 1'b1, 20'h7ffff, 2'b01, 16'h0077, -1, rd);
    access(0, 1'b1, 20'h7ffff, 2'b11, 16'hCAFE, -1, rd);
    access(0, 1'b0, 20'h7ffff, 2'b01, 16'h0000, -1, rd);
    check("oob_unchanged", {16'b0, rd}, 32'h0077);
    access(0, 1'b1, 20'h7fffe, 2'b11, 16'h1357, -1, rd);
    access(0, 1'b0, 20'h7fffe, 2'b11, 16'h0000, -1, rd);
    check("inb_edge", {16'b0, rd}, 32'h1357);
`endif

    // wait states
    access(1, 1'b1, 20'h00300, 2'b11, 16'h5A5A, -1, rd);
    access(1, 1'b0, 20'h00300, 2'b11, 16'h0000, -1, rd);
    check("wait_read", {16'b0, rd}, 32'h5A5A);
    access(1, 1'b1, 20'h00300, 2'b11, 16'hFFFF, 2, rd);
    access(1, 1'b0, 20'h00300, 2'b11, 16'h0000, -1, rd);
    check("abort_nowrite", {16'b0, rd}, 32'h5A5A);

    // reset in the middle of a pending write
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 20'h00300; sel[1] = 2'b11; wdat[1] = 16'h1111;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", {31'b0, ack[1]}, 32'd0);
    check("rst_mid_err", {31'b0, err[1]}, 32'd0);
    check("rst_mid_dat", {16'b0, rdat[1]}, 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_d[i] = '0; last_m[i] = 16'hffff;
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 20'h00300, 2'b11, 16'h0000, -1, rd);
    check("rst_no_write", {16'b0, rd}, 32'h5A5A);

    // randomized traffic on two small windows, one of them straddling the wrap
    for (int i = 0; i < 300; i++) begin
      d = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 0) ? 20'h00400 : 20'hffff8;
      a = a + AW'($urandom_range(0, 15));
      drop = (d == 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : -1;
      access(d, logic'($urandom_range(0, 1)), a, N'($urandom_range(0, 3)),
             DW'($urandom), drop, rd);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue0_empty", exp_q0.size(), 32'd0);
    check("queue1_empty", exp_q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
